// File: rtl/seg_scan_controller.sv
// Seven-segment scan scheduler: dwell prescaler, enabled-digit walk, frame-aligned value update.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_scan_controller #(
    parameter int unsigned DIV_CNT = 100000
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic [31:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [7:0]  digit_en,
    output logic [2:0]  select,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        frame_done
);

    localparam int unsigned CntW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;

    logic [CntW-1:0] cnt_q;
    logic [31:0]     disp_q;
    logic [31:0]     pend_q;
    logic            tick_q;

    logic            tick;
    logic [2:0]      next_sel;
    logic [2:0]      cand;
    logic            found;
    logic            boundary;
    logic            blank;
    logic [3:0]      nibble;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_seg = 7'h40;
            4'h1:    hex_seg = 7'h79;
            4'h2:    hex_seg = 7'h24;
            4'h3:    hex_seg = 7'h30;
            4'h4:    hex_seg = 7'h19;
            4'h5:    hex_seg = 7'h12;
            4'h6:    hex_seg = 7'h02;
            4'h7:    hex_seg = 7'h78;
            4'h8:    hex_seg = 7'h00;
            4'h9:    hex_seg = 7'h10;
            4'hA:    hex_seg = 7'h08;
            4'hB:    hex_seg = 7'h03;
            4'hC:    hex_seg = 7'h46;
            4'hD:    hex_seg = 7'h21;
            4'hE:    hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    assign tick   = (cnt_q == CntW'(DIV_CNT - 1));
    assign nibble = disp_q[{select, 2'b00} +: 4];

    // Search upward mod 8; offset 8 lands back on the current digit (single-digit hold).
    always_comb begin
        next_sel = select;
        cand     = select;
        found    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = select + 3'(k);
            if (!found && digit_en[cand]) begin
                next_sel = cand;
                found    = 1'b1;
            end
        end
        boundary = tick && found && (next_sel <= select);
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = (select != 3'd0) && ((disp_q >> {select, 2'b00}) == 32'd0);
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_ff @(posedge aclk) begin
        if (rst) begin
            cnt_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            tick_q      <= 1'b0;
            select      <= 3'd0;
            anode       <= 8'hFF;
            cathode     <= 7'h7F;
            frame_done  <= 1'b0;
            value_ready <= 1'b1;
        end else begin
            tick_q     <= tick;
            frame_done <= boundary;

            if (tick) begin
                cnt_q  <= '0;
                select <= next_sel;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end

            // Load and accept are exclusive: load needs the slot full, accept needs it empty.
            if (boundary && !value_ready) begin
                disp_q      <= pend_q;
                value_ready <= 1'b1;
            end else if (value_valid && value_ready) begin
                pend_q      <= value_in;
                value_ready <= 1'b0;
            end

            // Segment drive follows the select update by one cycle.
            if (digit_en == 8'h00) begin
                anode   <= 8'hFF;
                cathode <= 7'h7F;
            end else if (tick_q) begin
                if (digit_en[select] && !blank) begin
                    anode   <= ~(8'h01 << select);
                    cathode <= hex_seg(nibble);
                end else begin
                    anode   <= 8'hFF;
                    cathode <= 7'h7F;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomised bench for seg_scan_controller with a cycle-level behavioural model and literal pins.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_controller;

    localparam int unsigned DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int KFd = 0, KReadyLow = 1, KAnode7F = 2, KSelChange = 3;

    logic        aclk = 1'b0;
    logic        rst;
    logic [31:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [7:0]  digit_en;
    logic [2:0]  select;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    seg_scan_controller #(.DIV_CNT(DIV)) dut (
        .aclk        (aclk),
        .rst         (rst),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit_en    (digit_en),
        .select      (select),
        .anode       (anode),
        .cathode     (cathode),
        .frame_done  (frame_done)
    );

    always #5 aclk = ~aclk;

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] seg_on(input logic [3:0] n);
        // active-high {g,f,e,d,c,b,a}
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic bit blanked(input int s, input logic [31:0] d);
        return BLANK_EN && s != 0 && (d >> (4 * s)) == 32'd0;
    endfunction

    function automatic int next_digit(input int cur, input logic [7:0] en);
        for (int k = 1; k <= 8; k++) if (en[(cur + k) % 8]) return (cur + k) % 8;
        return cur;
    endfunction

    int          m_sel;
    logic [7:0]  m_anode;
    logic [6:0]  m_cath;
    logic        m_fd;
    logic        m_ready;
    logic [31:0] m_disp;
    logic [31:0] m_pend[$];
    bit          m_prev_tick;
    int unsigned m_since;

    always @(posedge aclk) begin
        int nxt;
        bit tick;
        bit wrap;
        if (rst) begin
            m_sel = 0; m_anode = 8'hFF; m_cath = 7'h7F; m_fd = 1'b0; m_ready = 1'b1;
            m_disp = 32'd0; m_pend.delete(); m_prev_tick = 1'b0; m_since = 0;
        end else begin
            tick = (m_since % DIV) == DIV - 1;
            m_since++;
            if (digit_en == 8'h00) begin
                m_anode = 8'hFF; m_cath = 7'h7F;
            end else if (m_prev_tick) begin
                if (digit_en[m_sel] && !blanked(m_sel, m_disp)) begin
                    m_anode = 8'hFF ^ (8'h01 << m_sel);
                    m_cath  = ~seg_on(4'((m_disp >> (4 * m_sel)) & 32'hF));
                end else begin
                    m_anode = 8'hFF; m_cath = 7'h7F;
                end
            end
            m_prev_tick = tick;
            nxt  = m_sel;
            wrap = 1'b0;
            if (tick && digit_en != 8'h00) begin
                nxt  = next_digit(m_sel, digit_en);
                wrap = nxt <= m_sel;
            end
            m_fd = wrap;
            if (wrap && m_pend.size() != 0) m_disp = m_pend.pop_front();
            else if (value_valid && m_pend.size() == 0) m_pend.push_back(value_in);
            m_sel   = nxt;
            m_ready = (m_pend.size() == 0);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(posedge aclk) begin
        #1;
        vectors++;
        if (select !== 3'(m_sel)) begin
            miscompares++; $display("FAIL select @%0t: got %0d want %0d", $time, select, m_sel);
        end
        if (anode !== m_anode) begin
            miscompares++; $display("FAIL anode @%0t: got %h want %h", $time, anode, m_anode);
        end
        if (cathode !== m_cath) begin
            miscompares++; $display("FAIL cathode @%0t: got %h want %h", $time, cathode, m_cath);
        end
        if (frame_done !== m_fd) begin
            miscompares++; $display("FAIL frame_done @%0t: got %b want %b", $time, frame_done, m_fd);
        end
        if (value_ready !== m_ready) begin
            miscompares++;
            $display("FAIL value_ready @%0t: got %b want %b", $time, value_ready, m_ready);
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int kind, input logic [2:0] old);
        case (kind)
            KFd:       return frame_done === 1'b1;
            KReadyLow: return value_ready === 1'b0;
            KAnode7F:  return anode === 8'h7F;
            default:   return select !== old;
        endcase
    endfunction

    task automatic wait_until(input string name, input int kind, input int budget);
        logic [2:0] old;
        int n;
        old = select;
        n   = 0;
        do begin
            step();
            n++;
        end while (!cond(kind, old) && n < budget);
        vectors++;
        if (!cond(kind, old)) begin
            miscompares++;
            $display("FAIL %s: got no event in %0d cycles want event", name, budget);
        end
    endtask

    task automatic lit_mask(input int cycles, output logic [7:0] m);
        m = 8'h00;
        repeat (cycles) begin
            step();
            m |= ~anode;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] mask;
        int n;
        int fd_cnt;
        rst = 1'b1; value_in = 32'd0; value_valid = 1'b0; digit_en = 8'hFF;
        repeat (3) step();
        rst = 1'b0;

        step();
        check("reset select", 32'(select), 32'd0);
        check("reset anode", 32'(anode), 32'hFF);
        check("reset cathode", 32'(cathode), 32'h7F);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset value_ready", 32'(value_ready), 32'd1);
        step(); step();
        check("pre-tick select", 32'(select), 32'd0);
        check("pre-tick anode", 32'(anode), 32'hFF);
        step();
        check("first tick select", 32'(select), 32'd1);

        value_in = 32'h7654_3210; value_valid = 1'b1;
        wait_until("accept 76543210", KReadyLow, 4);
        value_valid = 1'b0;
        wait_until("first boundary", KFd, 64);
        check("ready at boundary", 32'(value_ready), 32'd1);
        step();
        check("digit0 anode", 32'(anode), 32'hFE);
        check("digit0 cathode", 32'(cathode), 32'h40);
        wait_until("digit7 shown", KAnode7F, 40);
        check("digit7 cathode", 32'(cathode), 32'h78);
        wait_until("frame start", KFd, 64);
        n = 0;
        do begin step(); n++; end while (frame_done !== 1'b1 && n < 100);
        check("frame period", 32'(n), 32'd32);

        digit_en = 8'b1000_0101;
        wait_until("sparse boundary", KFd, 64);
        check("sparse sel 0", 32'(select), 32'd0);
        wait_until("sparse step 1", KSelChange, 16);
        check("sparse sel 2", 32'(select), 32'd2);
        wait_until("sparse step 2", KSelChange, 16);
        check("sparse sel 7", 32'(select), 32'd7);
        wait_until("sparse step 3", KSelChange, 16);
        check("sparse sel wrap", 32'(select), 32'd0);
        check("sparse wrap pulse", 32'(frame_done), 32'd1);

        digit_en = 8'b0001_0000;
        wait_until("single boundary", KFd, 64);
        check("single sel", 32'(select), 32'd4);
        fd_cnt = 0;
        repeat (16) begin step(); if (frame_done === 1'b1) fd_cnt++; end
        check("single pulses", 32'(fd_cnt), 32'd4);

        digit_en = 8'h00;
        fd_cnt = 0;
        repeat (20) begin step(); if (frame_done === 1'b1) fd_cnt++; end
        check("disabled pulses", 32'(fd_cnt), 32'd0);
        check("disabled anode", 32'(anode), 32'hFF);
        check("disabled select", 32'(select), 32'd4);

        digit_en = 8'hFF;
        value_in = 32'h0000_00A0; value_valid = 1'b1;
        wait_until("accept A", KReadyLow, 4);
        value_in = 32'h1234_5678;
        repeat (3) step();
        check("B stalls", 32'(value_ready), 32'd0);
        wait_until("A boundary", KFd, 64);
        check("ready after A load", 32'(value_ready), 32'd1);
        step();
        check("B accepted", 32'(value_ready), 32'd0);
        value_valid = 1'b0;
        lit_mask(31, mask);
        check("A lit mask", 32'(mask), BLANK_EN ? 32'h03 : 32'hFF);

        value_in = 32'hCAFE_F00D; value_valid = 1'b1;
        wait_until("accept C", KReadyLow, 4);
        value_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset select", 32'(select), 32'd0);
        check("midreset anode", 32'(anode), 32'hFF);
        check("midreset ready", 32'(value_ready), 32'd1);
        wait_until("post-reset boundary", KFd, 64);
        lit_mask(31, mask);
        check("zero lit mask", 32'(mask), BLANK_EN ? 32'h01 : 32'hFF);

        for (int c = 0; c < 3000; c++) begin
            value_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) value_in = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       digit_en = 8'h00;
                    1:       digit_en = 8'h01 << $urandom_range(0, 7);
                    default: digit_en = 8'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
